// File: rtl/bcd_hex_display_ctrl_if.sv
// Bus between the BCD source and the three-digit HEX display stage.
// The source drives the digit load and blink enable; the display returns segments and the error flag.
interface bcd_hex_display_ctrl_if;
  logic       load_i;
  logic [3:0] hundreds_i;
  logic [3:0] tens_i;
  logic [3:0] ones_i;
  logic       blink_en_i;
  logic [7:0] hex2_o;
  logic [7:0] hex1_o;
  logic [7:0] hex0_o;
  logic       err_o;

  modport master (
    output load_i, hundreds_i, tens_i, ones_i, blink_en_i,
    input  hex2_o, hex1_o, hex0_o, err_o
  );

  modport slave (
    input  load_i, hundreds_i, tens_i, ones_i, blink_en_i,
    output hex2_o, hex1_o, hex0_o, err_o
  );
endinterface

// File: rtl/bcd_hex_display_ctrl.sv
// Latches a 3-digit BCD value and drives three active-low 7-segment displays
// with optional leading-zero blanking, invalid-digit flagging and blinking.
module bcd_hex_display_ctrl #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_hex_display_ctrl_if.slave bus
);
  localparam int NUM_DIG  = 3;
  localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int PW       = $clog2(HALF) + 1;
  localparam logic [PW-1:0] TC = PW'(HALF - 1);

  typedef enum logic [1:0] {EMPTY, ON, OFF} state_e;

  state_e                      state_q, state_d;
  logic [PW-1:0]               presc_q, presc_d;
  logic [NUM_DIG-1:0][3:0]     dig_q, dig_d;   // [2]=hundreds, [0]=ones
  logic [NUM_DIG-1:0][7:0]     hex_q, hex_d;
  logic                        err_q, err_d;
  logic [NUM_DIG-1:0]          blank;
  logic                        tc;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'h86;
    endcase
  endfunction

  assign tc = (presc_q == TC);

  // A load always wins, so a fresh value is shown for a full half-period.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dig_d   = dig_q;
    if (bus.load_i) begin
      dig_d   = {bus.hundreds_i, bus.tens_i, bus.ones_i};
      state_d = ON;
      presc_d = '0;
    end else begin
      case (state_q)
        EMPTY: ;
        ON: begin
          if (!bus.blink_en_i) begin
            presc_d = '0;
          end else if (tc) begin
            presc_d = '0;
            state_d = OFF;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        OFF: begin
          if (!bus.blink_en_i || tc) begin
            presc_d = '0;
            state_d = ON;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: begin
          state_d = EMPTY;
          presc_d = '0;
        end
      endcase
    end
  end

  // Only hundreds and tens can be blanked; ones always shows.
  assign blank = {(BLANK_LZ != 0) && (dig_q[2] == 4'd0),
                  (BLANK_LZ != 0) && (dig_q[2] == 4'd0) && (dig_q[1] == 4'd0),
                  1'b0};

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    assign hex_d[g] = (state_q == ON && !blank[g]) ? seg7(dig_q[g]) : 8'hFF;
  end

  always_comb begin
    err_d = 1'b0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (dig_q[i] > 4'd9) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      presc_q <= '0;
      dig_q   <= '0;
      hex_q   <= {NUM_DIG{8'hFF}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dig_q   <= dig_d;
      hex_q   <= hex_d;
      err_q   <= err_d;
    end
  end

  assign bus.hex2_o = hex_q[2];
  assign bus.hex1_o = hex_q[1];
  assign bus.hex0_o = hex_q[0];
  assign bus.err_o  = err_q;
endmodule

// File: tb/tb_bcd_hex_display_ctrl.sv
// Bench for bcd_hex_display_ctrl: three configurations share one stimulus stream,
// a phase-counting model predicts every output cycle, literal checks pin key points.
module tb_bcd_hex_display_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load = 1'b0;
  logic [3:0] hi = 4'd0, ti = 4'd0, oi = 4'd0;
  logic       blink = 1'b0;
  bit         chk_en = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  // a: default, b: no blanking, c: HALF=4 for blink tests
  bcd_hex_display_ctrl_if ifa ();
  bcd_hex_display_ctrl_if ifb ();
  bcd_hex_display_ctrl_if ifc ();

  assign ifa.load_i = load;  assign ifa.hundreds_i = hi;  assign ifa.tens_i = ti;
  assign ifa.ones_i = oi;    assign ifa.blink_en_i = blink;
  assign ifb.load_i = load;  assign ifb.hundreds_i = hi;  assign ifb.tens_i = ti;
  assign ifb.ones_i = oi;    assign ifb.blink_en_i = blink;
  assign ifc.load_i = load;  assign ifc.hundreds_i = hi;  assign ifc.tens_i = ti;
  assign ifc.ones_i = oi;    assign ifc.blink_en_i = blink;

  bcd_hex_display_ctrl #(.CLK_HZ(50_000_000), .BLINK_HZ(2), .BLANK_LZ(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  bcd_hex_display_ctrl #(.CLK_HZ(50_000_000), .BLINK_HZ(2), .BLANK_LZ(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  bcd_hex_display_ctrl #(.CLK_HZ(8), .BLINK_HZ(1), .BLANK_LZ(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  logic [2:0][24:0] act;
  assign act = {{ifc.hex2_o, ifc.hex1_o, ifc.hex0_o, ifc.err_o},
                {ifb.hex2_o, ifb.hex1_o, ifb.hex0_o, ifb.err_o},
                {ifa.hex2_o, ifa.hex1_o, ifa.hex0_o, ifa.err_o}};

  // ---------------- model ----------------
  localparam logic [24:0] DARK = {24'hFFFFFF, 1'b0};
  logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h86, 8'h86, 8'h86, 8'h86, 8'h86, 8'h86};
  int         half_c [3] = '{12_500_000, 12_500_000, 4};
  bit         blz_c  [3] = '{1'b1, 1'b0, 1'b1};
  bit         loaded [3];
  bit         dark   [3];
  int         cnt    [3];
  logic [3:0] mh [3], mt [3], mo [3];
  logic [24:0] expv [3] = '{DARK, DARK, DARK};

  // What the display shows for the currently held model value.
  function automatic logic [24:0] view(input int i);
    logic [7:0] h2, h1, h0;
    bit e;
    e = (mh[i] > 4'd9) || (mt[i] > 4'd9) || (mo[i] > 4'd9);
    if (!loaded[i] || dark[i]) return {24'hFFFFFF, e};
    h2 = (blz_c[i] && mh[i] == 4'd0) ? 8'hFF : SEG[mh[i]];
    h1 = (blz_c[i] && mh[i] == 4'd0 && mt[i] == 4'd0) ? 8'hFF : SEG[mt[i]];
    h0 = SEG[mo[i]];
    return {h2, h1, h0, e};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        loaded[i] = 0; dark[i] = 0; cnt[i] = 0;
        mh[i] = 4'd0; mt[i] = 4'd0; mo[i] = 4'd0;
        expv[i] = DARK;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        expv[i] = view(i);
        if (load) begin
          loaded[i] = 1; dark[i] = 0; cnt[i] = 0;
          mh[i] = hi; mt[i] = ti; mo[i] = oi;
        end else if (loaded[i]) begin
          if (!blink) begin
            dark[i] = 0; cnt[i] = 0;
          end else begin
            cnt[i]++;
            if (cnt[i] == half_c[i]) begin
              dark[i] = !dark[i];
              cnt[i] = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (act[i] !== expv[i]) begin
          n_fail++;
          $display("FAIL cyc_dut%0d t=%0t got %h want %h", i, $time, act[i], expv[i]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic lit(input int i, input string nm, input logic [24:0] want);
    n_tests++;
    if (act[i] !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d got %h want %h", nm, i, act[i], want);
    end
  endtask

  // load_i is sampled at the second posedge inside this task
  task automatic drive_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    @(posedge clk); #1;
    load = 1'b1; hi = h; ti = t; oi = o;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic see();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // reset, no load
    repeat (5) @(posedge clk);
    @(negedge clk);
    lit(0, "rst_a", DARK);
    lit(2, "rst_c", DARK);

    // encoding and leading-zero blanking
    drive_load(4'd2, 4'd5, 4'd5); see();
    lit(0, "ld255_a", {8'hA4, 8'h92, 8'h92, 1'b0});
    lit(1, "ld255_b", {8'hA4, 8'h92, 8'h92, 1'b0});
    drive_load(4'd0, 4'd0, 4'd7); see();
    lit(0, "ld007_a", {8'hFF, 8'hFF, 8'hF8, 1'b0});
    drive_load(4'd0, 4'd0, 4'd0); see();
    lit(0, "ld000_a", {8'hFF, 8'hFF, 8'hC0, 1'b0});
    lit(1, "ld000_b", {8'hC0, 8'hC0, 8'hC0, 1'b0});
    drive_load(4'd0, 4'd4, 4'd0); see();
    lit(0, "ld040_a", {8'hFF, 8'h99, 8'hC0, 1'b0});
    drive_load(4'd0, 4'd12, 4'd3); see();
    lit(1, "ldC_b", {8'hC0, 8'h86, 8'hB0, 1'b1});
    lit(0, "ldC_a", {8'hFF, 8'h86, 8'hB0, 1'b1});
    drive_load(4'd1, 4'd2, 4'd3); see();
    lit(1, "ld123_b", {8'hF9, 8'hA4, 8'hB0, 1'b0});

    // back-to-back loads every cycle
    @(posedge clk); #1;
    load = 1'b1; hi = 4'd3; ti = 4'd4; oi = 4'd5;
    @(posedge clk); #1;
    hi = 4'd9; ti = 4'd15; oi = 4'd9;
    @(posedge clk); #1;
    hi = 4'd0; ti = 4'd0; oi = 4'd1;
    @(posedge clk); #1;
    load = 1'b0;
    see();
    lit(0, "b2b_a", {8'hFF, 8'hFF, 8'hF9, 1'b0});

    // blinking with HALF=4
    blink = 1'b1;
    drive_load(4'd1, 4'd2, 4'd8); see();
    lit(2, "blk_on1", {8'hF9, 8'hA4, 8'h80, 1'b0});
    repeat (4) @(negedge clk);
    lit(2, "blk_off1", DARK);
    repeat (4) @(negedge clk);
    lit(2, "blk_on2", {8'hF9, 8'hA4, 8'h80, 1'b0});
    repeat (4) @(negedge clk);
    lit(2, "blk_off2", DARK);
    blink = 1'b0;
    @(negedge clk);
    lit(2, "unblk_wait", DARK);
    @(negedge clk);
    lit(2, "unblk_vis", {8'hF9, 8'hA4, 8'h80, 1'b0});
    repeat (8) @(negedge clk);
    lit(2, "unblk_hold", {8'hF9, 8'hA4, 8'h80, 1'b0});

    // load on terminal-count cycle of ON
    blink = 1'b1;
    drive_load(4'd1, 4'd2, 4'd8);
    repeat (2) @(posedge clk);
    drive_load(4'd0, 4'd9, 4'd9);
    see();
    lit(2, "tc_ld_vis0", {8'hFF, 8'h90, 8'h90, 1'b0});
    repeat (3) @(negedge clk);
    lit(2, "tc_ld_vis3", {8'hFF, 8'h90, 8'h90, 1'b0});
    @(negedge clk);
    lit(2, "tc_ld_dark", DARK);

    // async reset during OFF with err set
    drive_load(4'd1, 4'd10, 4'd8); see();
    lit(2, "err_on", {8'hF9, 8'h86, 8'h80, 1'b1});
    repeat (5) @(negedge clk);
    lit(2, "err_off", {24'hFFFFFF, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    lit(2, "arst_c", DARK);
    lit(0, "arst_a", DARK);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    lit(2, "post_rst_c", DARK);
    lit(1, "post_rst_b", DARK);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
